// File: rtl/sync_fifo_buffer_pkg.sv
// Shared constants and the push/pop operation encoding for the staging FIFO.
// The default geometry is the analyser's 1-bit x 64-deep serial head-data buffer.
package sync_fifo_buffer_pkg;

   localparam int DEFAULT_DATA_WIDTH = 1;
   localparam int DEFAULT_CAPACITY   = 64;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e decode_op(input logic push, input logic pop);
      return fifo_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/sync_fifo_buffer_storage.sv
// Simple dual-port register file: synchronous write port, asynchronous read port.
module sync_fifo_buffer_storage #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; emptiness is tracked by the level counter,
   // so stale contents are never observable and resetting them would only cost logic.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_buffer.sv
// First-word-fall-through single-clock FIFO; any depth >= 2, pointers wrap by compare.
module sync_fifo_buffer
   import sync_fifo_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CAPACITY   = DEFAULT_CAPACITY
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               write_enable,
   input  logic [DATA_WIDTH-1:0]              write_data,
   input  logic                               read_enable,
   output logic [DATA_WIDTH-1:0]              read_data,
   output logic                               empty,
   output logic                               full,
   output logic [$clog2(CAPACITY+1)-1:0]      level
);

   localparam int PTR_W = $clog2(CAPACITY);
   localparam int LVL_W = $clog2(CAPACITY + 1);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(CAPACITY - 1);
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(CAPACITY);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] head_data;
   fifo_op_e              op;

   assign empty = (level_q == '0);
   assign full  = (level_q == FULL_LEVEL);
   assign level = level_q;

   // A pop frees a slot on the same edge, so a full FIFO still accepts a write alongside a read.
   assign push = write_enable && (!full || read_enable);
   assign pop  = read_enable && !empty;
   assign op   = decode_op(push, pop);

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case (op)
         OP_PUSH: level_d = level_q + 1'b1;
         OP_POP:  level_d = level_q - 1'b1;
         OP_IDLE,
         OP_BOTH: level_d = level_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   sync_fifo_buffer_storage #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (CAPACITY),
      .ADDR_W    (PTR_W)
   ) u_storage (
      .clk  (clk),
      .we   (push && !reset),
      .waddr(wr_ptr_q),
      .wdata(write_data),
      .raddr(rd_ptr_q),
      .rdata(head_data)
   );

   assign read_data = empty ? '0 : head_data;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed bench for the FIFO: a 64x8 instance and a 5x8 instance checked against queue models.
module tb_sync_fifo_buffer;

   localparam int CAP_A = 64;
   localparam int CAP_B = 5;

   logic       clk = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       check_en = 1'b0;

   logic       rst_a, we_a, re_a, empty_a, full_a;
   logic [7:0] wd_a, rd_a;
   logic [6:0] lvl_a;
   logic       rst_b, we_b, re_b, empty_b, full_b;
   logic [7:0] wd_b, rd_b;
   logic [2:0] lvl_b;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   bit         pop_a, push_a, pop_b, push_b;

   always #5 clk = ~clk;

   sync_fifo_buffer #(.DATA_WIDTH(8), .CAPACITY(CAP_A)) dut_a (
      .clk(clk), .reset(rst_a), .write_enable(we_a), .write_data(wd_a),
      .read_enable(re_a), .read_data(rd_a), .empty(empty_a), .full(full_a), .level(lvl_a)
   );

   sync_fifo_buffer #(.DATA_WIDTH(8), .CAPACITY(CAP_B)) dut_b (
      .clk(clk), .reset(rst_b), .write_enable(we_b), .write_data(wd_b),
      .read_enable(re_b), .read_data(rd_b), .empty(empty_b), .full(full_b), .level(lvl_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue models: a pop takes the head, a push appends; capacity counts the slot a pop frees.
   always @(posedge clk) begin
      if (rst_a) begin
         qa.delete();
      end else begin
         pop_a  = re_a && (qa.size() > 0);
         push_a = we_a && ((qa.size() < CAP_A) || re_a);
         if (pop_a)  void'(qa.pop_front());
         if (push_a) qa.push_back(wd_a);
      end
      if (rst_b) begin
         qb.delete();
      end else begin
         pop_b  = re_b && (qb.size() > 0);
         push_b = we_b && ((qb.size() < CAP_B) || re_b);
         if (pop_b)  void'(qb.pop_front());
         if (push_b) qb.push_back(wd_b);
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("a_read_data", 32'(rd_a), (qa.size() > 0) ? 32'(qa[0]) : 32'd0);
         check("a_empty", 32'(empty_a), 32'(qa.size() == 0));
         check("a_full", 32'(full_a), 32'(qa.size() == CAP_A));
         check("a_level", 32'(lvl_a), 32'(qa.size()));
         check("b_read_data", 32'(rd_b), (qb.size() > 0) ? 32'(qb[0]) : 32'd0);
         check("b_empty", 32'(empty_b), 32'(qb.size() == 0));
         check("b_full", 32'(full_b), 32'(qb.size() == CAP_B));
         check("b_level", 32'(lvl_b), 32'(qb.size()));
      end
   end

   logic [1:0] pat [8] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
   int         wr_cnt, out_cnt;

   initial begin
      rst_a = 1'b1; we_a = 1'b1; wd_a = 8'h11; re_a = 1'b0;
      rst_b = 1'b1; we_b = 1'b1; wd_b = 8'h22; re_b = 1'b0;
      step();
      check_en = 1'b1;
      step();
      check("reset_empty", 32'(empty_a), 32'd1);
      check("reset_full", 32'(full_a), 32'd0);
      check("reset_level", 32'(lvl_a), 32'd0);
      check("reset_rdata", 32'(rd_a), 32'd0);
      rst_a = 1'b0; we_a = 1'b0; rst_b = 1'b0; we_b = 1'b0;
      step();
      check("reset_no_store", 32'(empty_a), 32'd1);

      // Fill to full, drop a 65th write, then push+pop while full.
      for (int i = 0; i < CAP_A; i++) begin
         we_a = 1'b1; wd_a = 8'(i);
         step();
      end
      check("fill_full", 32'(full_a), 32'd1);
      check("fill_level", 32'(lvl_a), 32'd64);
      wd_a = 8'hAA;
      step();
      check("drop_level", 32'(lvl_a), 32'd64);
      check("drop_head", 32'(rd_a), 32'h00);
      wd_a = 8'h77; re_a = 1'b1;
      step();
      check("full_rw_level", 32'(lvl_a), 32'd64);
      we_a = 1'b0;
      for (int i = 1; i < CAP_A; i++) begin
         check("drain_order", 32'(rd_a), 32'(i));
         step();
      end
      check("drain_last_77", 32'(rd_a), 32'h77);
      step();
      re_a = 1'b0;
      check("drain_empty", 32'(empty_a), 32'd1);

      // Fall-through of a single word.
      we_a = 1'b1; wd_a = 8'h5A;
      step();
      we_a = 1'b0;
      check("ft_data", 32'(rd_a), 32'h5A);
      check("ft_not_empty", 32'(empty_a), 32'd0);
      re_a = 1'b1;
      step();
      re_a = 1'b0;
      check("ft_pop_data", 32'(rd_a), 32'd0);
      check("ft_pop_empty", 32'(empty_a), 32'd1);

      // Push+pop on an empty FIFO: no bypass.
      we_a = 1'b1; re_a = 1'b1; wd_a = 8'hC3;
      step();
      we_a = 1'b0; re_a = 1'b0;
      check("empty_rw_level", 32'(lvl_a), 32'd1);
      check("empty_rw_data", 32'(rd_a), 32'hC3);
      re_a = 1'b1;
      step();
      re_a = 1'b0;

      // Mid-stream reset discards stored words.
      for (int i = 0; i < 10; i++) begin
         we_a = 1'b1; wd_a = 8'(8'h80 + i);
         step();
      end
      we_a = 1'b0;
      check("mid_level_10", 32'(lvl_a), 32'd10);
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      check("mid_reset_empty", 32'(empty_a), 32'd1);
      we_a = 1'b1; wd_a = 8'h33;
      step();
      we_a = 1'b0;
      check("mid_reset_33", 32'(rd_a), 32'h33);
      re_a = 1'b1;
      step();
      re_a = 1'b0;

      // Non-power-of-two depth: interleaved stream of 20 words through 5 slots.
      wr_cnt = 0; out_cnt = 0;
      for (int c = 0; c < 200 && out_cnt < 20; c++) begin
         we_b = pat[c % 8][1] && (wr_cnt < 20);
         re_b = pat[c % 8][0] || (wr_cnt == 20);
         wd_b = 8'(8'h40 + wr_cnt);
         if (re_b && qb.size() > 0) begin
            check("b_order", 32'(rd_b), 32'(8'h40 + out_cnt));
            out_cnt++;
         end
         if (we_b && (qb.size() < CAP_B || re_b)) wr_cnt++;
         step();
      end
      we_b = 1'b0; re_b = 1'b0;
      check("b_stream_done", 32'(out_cnt), 32'd20);
      check("b_final_empty", 32'(empty_b), 32'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
